bsram_dump: RTL

//  Read-back path for the program BSRAM: on a start pulse, reads DUMP_WORDS 16-bit words

---
 rtl/bsram_dump_pkg.sv | 24 ++
 rtl/bsram_dump_if.sv | 26 ++
 rtl/bsram_dump.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bsram_dump_pkg.sv
// Shared types and defaults for the BSRAM read-back (dump) path.
// Optional feature macro used by users of this package: DUMP_CHECKSUM_EN.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HI,
    LO,
    CSUM,
    FIN
  } dump_state_t;

  localparam int BYTES_PER_WORD     = 2;
  localparam int DEFAULT_DUMP_WORDS = 16;
  localparam int DEFAULT_READ_LAT   = 1;

  // Byte lane of a 16-bit word in transmit order: lane 0 is the high byte.
  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic lane);
    return lane ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/bsram_dump_if.sv
// Control, BSRAM read port and UART byte stream of the dump block.
// slave = the dump engine, master = its surroundings (top or a bench).
interface bsram_dump_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_dout;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  start, mem_dout, tx_ready,
    output busy, done, mem_ce, mem_ad, tx_data, tx_valid
  );

  modport master (
    output start, mem_dout, tx_ready,
    input  busy, done, mem_ce, mem_ad, tx_data, tx_valid
  );
endinterface

// File: rtl/bsram_dump.sv
// Streams BSRAM words 0..DUMP_WORDS-1 to the UART byte interface, high byte first.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module bsram_dump
  import dump_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int DUMP_WORDS = DEFAULT_DUMP_WORDS,
  parameter int READ_LAT   = DEFAULT_READ_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  bsram_dump_if.slave bus
);

  // One spare bit so a full 2**ADDR_W dump never wraps the counter.
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DUMP_WORDS - 1);
  localparam logic [1:0]       LAT_LOAD  = 2'(READ_LAT - 1);

  dump_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] word_q, word_d;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      word_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      word_q  <= word_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.mem_ad = cnt_q[ADDR_W-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    word_d       = word_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.mem_ce   = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          cnt_d   = '0;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end

      ISSUE: begin
        bus.busy   = 1'b1;
        bus.mem_ce = 1'b1;
        lat_d      = LAT_LOAD;
        state_d    = WAIT;
      end

      // Read data is taken only on the last wait cycle, when it is guaranteed valid.
      WAIT: begin
        bus.busy = 1'b1;
        if (lat_q == 2'd0) begin
          word_d  = bus.mem_dout;
          state_d = HI;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      HI: begin
        bus.busy     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = word_byte(word_q[15:0], 1'b0);
        if (bus.tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum_q ^ word_byte(word_q[15:0], 1'b0);
`endif
          state_d = LO;
        end
      end

      LO: begin
        bus.busy     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = word_byte(word_q[15:0], 1'b1);
        if (bus.tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum_q ^ word_byte(word_q[15:0], 1'b1);
`endif
          if (cnt_q == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FIN;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end

`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        bus.busy     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum_q;
        if (bus.tx_ready) begin
          state_d = FIN;
        end
      end
`endif

      FIN: begin
        bus.done = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
